// File: rtl/ahb_sram_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ahb_sram_if : AHB-Lite slave front end for a single-port synchronous SRAM
// rev 1.0
// ---------------------------------------------------------------------------
module ahb_sram_if #(
  parameter int ABITS = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             hsel_i,
  input  logic [31:0]      haddr_i,
  input  logic [1:0]       htrans_i,
  input  logic             hwrite_i,
  input  logic [2:0]       hsize_i,
  input  logic [31:0]      hwdata_i,
  input  logic             hready_i,
  output logic [31:0]      hrdata_o,
  output logic             hreadyout_o,
  output logic             hresp_o,
  output logic [ABITS-1:0] mem_addr_o,
  output logic             mem_we_o,
  output logic [3:0]       mem_be_o,
  output logic [31:0]      mem_din_o,
  input  logic [31:0]      mem_dout_i
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WRITE   = 3'd1,
    S_READ    = 3'd2,
    S_RD_WAIT = 3'd3,
    S_ERR1    = 3'd4,
    S_ERR2    = 3'd5
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [ABITS-1:0] wr_addr;
  logic [ABITS-1:0] rd_addr;
  logic [3:0]       wr_be;
  logic             ready_q;
  logic             resp_q;
  logic             we_q;
  logic             rd_q;

  logic             accept;
  logic             bad_xfer;
  logic             load;
  logic [ABITS-1:0] bus_word;
  logic [3:0]       bus_be;
  logic             unused_bits;

  assign accept      = hsel_i & hready_i & htrans_i[1];
  assign bus_word    = haddr_i[ABITS+1:2];
  assign unused_bits = ^{haddr_i[31:ABITS+2], htrans_i[0]};
  // ready_q is low only in RD_WAIT/ERR1, where no address phase may be taken
  assign load        = accept & ~bad_xfer & ready_q;

  always_comb begin
    bus_be   = 4'b0000;
    bad_xfer = 1'b0;
    case (hsize_i)
      3'd0: bus_be = 4'b0001 << haddr_i[1:0];
      3'd1: begin
        bus_be   = haddr_i[1] ? 4'b1100 : 4'b0011;
        bad_xfer = haddr_i[0];
      end
      3'd2: begin
        bus_be   = 4'b1111;
        bad_xfer = |haddr_i[1:0];
      end
      default: bad_xfer = 1'b1;
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      S_RD_WAIT: next_state = S_READ;
      S_ERR1:    next_state = S_ERR2;
      default: begin
        if (hready_i) begin
          if (!accept)
            next_state = S_IDLE;
          else if (bad_xfer)
            next_state = S_ERR1;
          else if (hwrite_i)
            next_state = S_WRITE;
          else if (state == S_WRITE)
            next_state = S_RD_WAIT;
          else
            next_state = S_READ;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= S_IDLE;
      wr_addr <= '0;
      wr_be   <= 4'b0000;
      rd_addr <= '0;
      ready_q <= 1'b1;
      resp_q  <= 1'b0;
      we_q    <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state   <= next_state;
      ready_q <= (next_state != S_RD_WAIT) && (next_state != S_ERR1);
      resp_q  <= (next_state == S_ERR1) || (next_state == S_ERR2);
      we_q    <= (next_state == S_WRITE);
      rd_q    <= (next_state == S_READ);
      if (load) begin
        if (hwrite_i) begin
          wr_addr <= bus_word;
          wr_be   <= bus_be;
        end else begin
          rd_addr <= bus_word;
        end
      end
    end
  end

  // A read seen during a write data phase is deferred to RD_WAIT, so the
  // SRAM has already committed the write when the read is issued.
  always_comb begin
    mem_addr_o = '0;
    if (we_q)
      mem_addr_o = wr_addr;
    else if (state == S_RD_WAIT)
      mem_addr_o = rd_addr;
    else if (load && !hwrite_i && !rst_i)
      mem_addr_o = bus_word;
  end

  assign hreadyout_o = ready_q;
  assign hresp_o     = resp_q;
  assign hrdata_o    = rd_q ? mem_dout_i : 32'h0;
  assign mem_we_o    = we_q;
  assign mem_be_o    = we_q ? wr_be : 4'b0000;
  assign mem_din_o   = hwdata_i;

endmodule
`default_nettype wire

// File: tb/tb_ahb_sram_if.sv
`default_nettype none
// Testbench for ahb_sram_if: pipelined AHB master, SRAM model and byte-level reference memory.
module tb_ahb_sram_if;

  localparam int ABITS = 10;
  localparam int LIMIT = 20000;

  logic             clk = 1'b0;
  logic             rst;
  logic             hsel;
  logic [31:0]      haddr;
  logic [1:0]       htrans;
  logic             hwrite;
  logic [2:0]       hsize;
  logic [31:0]      hwdata;
  logic [31:0]      hrdata;
  logic             hreadyout;
  logic             hresp;
  logic [ABITS-1:0] mem_addr;
  logic             mem_we;
  logic [3:0]       mem_be;
  logic [31:0]      mem_din;
  logic [31:0]      mem_dout;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  ahb_sram_if #(.ABITS(ABITS)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .hsel_i     (hsel),
    .haddr_i    (haddr),
    .htrans_i   (htrans),
    .hwrite_i   (hwrite),
    .hsize_i    (hsize),
    .hwdata_i   (hwdata),
    .hready_i   (hreadyout),
    .hrdata_o   (hrdata),
    .hreadyout_o(hreadyout),
    .hresp_o    (hresp),
    .mem_addr_o (mem_addr),
    .mem_we_o   (mem_we),
    .mem_be_o   (mem_be),
    .mem_din_o  (mem_din),
    .mem_dout_i (mem_dout)
  );

  // Single-port SRAM with registered read data
  logic [31:0] sram [0:(1<<ABITS)-1];
  always_ff @(posedge clk) begin
    if (mem_we)
      for (int k = 0; k < 4; k++)
        if (mem_be[k]) sram[mem_addr][8*k +: 8] <= mem_din[8*k +: 8];
    mem_dout <= sram[mem_addr];
  end

  // Reference: plain byte array covering the exercised 256-byte window
  logic [7:0] model [0:255];

  typedef struct packed {
    logic        vld;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } op_t;

  op_t ops[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic is_err(input op_t o);
    return (o.size > 3'd2) || ((o.addr & ((32'd1 << o.size) - 32'd1)) != 32'd0);
  endfunction

  function automatic logic [3:0] exp_be(input op_t o);
    int nbytes = 1 << o.size;
    return 4'(((1 << nbytes) - 1) << o.addr[1:0]);
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    int b = int'({a[7:2], 2'b00});
    return {model[b+3], model[b+2], model[b+1], model[b]};
  endfunction

  task automatic model_write(input op_t o);
    int b = int'({o.addr[7:2], 2'b00});
    int lo = int'(o.addr[1:0]);
    for (int k = lo; k < lo + (1 << o.size); k++)
      model[b+k] = o.wdata[8*k +: 8];
  endtask

  task automatic push(input logic w, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
    op_t o;
    o.vld = 1'b1; o.wr = w; o.addr = a; o.size = s; o.wdata = d;
    ops.push_back(o);
  endtask

  task automatic push_idle();
    op_t o;
    o = '0;
    ops.push_back(o);
  endtask

  // Drives the queued transfers as a pipelined master; starts and ends just after a rising edge.
  task automatic run_ops();
    op_t  cur;
    op_t  dp;
    logic dp_err;
    int   dp_wait;
    int   waits;
    int   idx;
    int   cyc;
    logic rdy;
    dp = '0; dp_err = 1'b0; dp_wait = 0; waits = 0; idx = 0; cyc = 0;
    while ((idx < ops.size() || dp.vld) && cyc < LIMIT) begin
      cyc++;
      if (idx < ops.size()) cur = ops[idx];
      else cur = '0;
      hsel   = cur.vld;
      htrans = cur.vld ? 2'b10 : 2'b00;
      haddr  = cur.addr;
      hwrite = cur.wr;
      hsize  = cur.size;
      hwdata = (dp.vld && dp.wr) ? dp.wdata : 32'h0;
      @(negedge clk);
      if (dp.vld) begin
        if (hreadyout) begin
          check("wait_states", 32'(waits), 32'(dp_wait));
          check("hresp", 32'(hresp), 32'(dp_err));
          if (dp_err)
            check("err_rdata", hrdata, 32'h0);
          else if (!dp.wr)
            check("rdata", hrdata, model_word(dp.addr));
          if (dp.wr && !dp_err) begin
            check("we", 32'(mem_we), 32'd1);
            check("waddr", 32'(mem_addr), 32'(dp.addr[ABITS+1:2]));
            check("be", 32'(mem_be), 32'(exp_be(dp)));
            check("din", mem_din, dp.wdata);
            model_write(dp);
          end else begin
            check("we_quiet", 32'(mem_we), 32'd0);
          end
        end else begin
          waits++;
          check("hresp_wait", 32'(hresp), 32'(dp_err));
          check("we_wait", 32'(mem_we), 32'd0);
        end
      end else begin
        check("we_idle", 32'(mem_we), 32'd0);
        check("rdata_idle", hrdata, 32'h0);
      end
      rdy = hreadyout;
      @(posedge clk); #1;
      if (rdy) begin
        waits = 0;
        if (idx < ops.size()) begin
          if (!cur.vld) dp_wait = 0;
          else if (is_err(cur)) dp_wait = 1;
          else if (!cur.wr && dp.vld && dp.wr && !dp_err) dp_wait = 1;
          else dp_wait = 0;
          dp_err = cur.vld && is_err(cur);
          dp = cur;
          idx++;
        end else begin
          dp = '0;
        end
      end
    end
    check("no_timeout", 32'(cyc < LIMIT), 32'd1);
    ops.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [2:0]  sz;
    int          r;
    rst = 1'b1; hsel = 1'b0; haddr = 32'h0; htrans = 2'b00;
    hwrite = 1'b0; hsize = 3'd0; hwdata = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(hreadyout), 32'd1);
    check("rst_resp", 32'(hresp), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_be", 32'(mem_be), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_rdata", hrdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_we", 32'(mem_we), 32'd0);
      check("idle_ready", 32'(hreadyout), 32'd1);
    end
    @(posedge clk); #1;

    // Establish known contents across the test window
    for (int i = 0; i < 64; i++) push(1'b1, 32'(i * 4), 3'd2, $urandom);
    push_idle();
    run_ops();

    // Word write, idle, read back
    push(1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
    push_idle();
    push(1'b0, 32'h10, 3'd2, 32'h0);
    push_idle();
    run_ops();
    check("deadbeef", model_word(32'h10), 32'hDEADBEEF);

    // Byte writes followed immediately by a read
    push(1'b1, 32'h20, 3'd2, 32'h0);
    push_idle();
    push(1'b1, 32'h21, 3'd0, 32'h11111111);
    push(1'b1, 32'h22, 3'd0, 32'h22222222);
    push(1'b0, 32'h20, 3'd2, 32'h0);
    push_idle();
    run_ops();
    check("byte_merge", model_word(32'h20), 32'h00221100);

    // Misaligned halfword then a normal read
    push(1'b0, 32'h03, 3'd1, 32'h0);
    push(1'b0, 32'h00, 3'd2, 32'h0);
    push_idle();
    run_ops();

    // Back-to-back reads
    push(1'b1, 32'h0, 3'd2, 32'd1);
    push(1'b1, 32'h4, 3'd2, 32'd2);
    push(1'b1, 32'h8, 3'd2, 32'd3);
    push_idle();
    push(1'b0, 32'h0, 3'd2, 32'h0);
    push(1'b0, 32'h4, 3'd2, 32'h0);
    push(1'b0, 32'h8, 3'd2, 32'h0);
    push_idle();
    run_ops();

    // Reset during a write data phase drops the write
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h40; hwrite = 1'b1; hsize = 3'd2;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'hCAFEF00D;
    check("we_before_rst", 32'(mem_we), 32'd1);
    rst = 1'b1;
    #1;
    check("we_async_rst", 32'(mem_we), 32'd0);
    check("ready_async_rst", 32'(hreadyout), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    push(1'b0, 32'h40, 3'd2, 32'h0);
    push_idle();
    run_ops();

    // Randomized mix; upper address bits must be ignored
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r < 2) begin
        push_idle();
      end else begin
        a = 32'($urandom_range(0, 255));
        if ($urandom_range(0, 3) == 0) a = a | ($urandom << 12);
        if ($urandom_range(0, 15) == 0) sz = 3'($urandom_range(3, 7));
        else sz = 3'($urandom_range(0, 2));
        if (sz <= 3'd2 && $urandom_range(0, 7) != 0)
          a = a & ~((32'd1 << sz) - 32'd1);
        push(r < 6, a, sz, $urandom);
      end
    end
    push_idle();
    run_ops();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
